// File: rtl/stat_pkg.sv
// Shared constants, FSM state type and instruction classifier for the
// retired-instruction statistics unit.
package stat_pkg;

  localparam int unsigned NUM_CH = 8;

  localparam logic [2:0] CH_R       = 3'd0;
  localparam logic [2:0] CH_I       = 3'd1;
  localparam logic [2:0] CH_J       = 3'd2;
  localparam logic [2:0] CH_SYSCALL = 3'd3;
  localparam logic [2:0] CH_LOAD    = 3'd4;
  localparam logic [2:0] CH_STORE   = 3'd5;
  localparam logic [2:0] CH_BRANCH  = 3'd6;
  localparam logic [2:0] CH_TOTAL   = 3'd7;

  localparam logic [5:0] OP_RTYPE     = 6'h00;
  localparam logic [5:0] OP_J         = 6'h02;
  localparam logic [5:0] OP_JAL       = 6'h03;
  localparam logic [5:0] OP_BRANCH_LO = 6'h04;
  localparam logic [5:0] OP_BRANCH_HI = 6'h07;
  localparam logic [5:0] OP_LOAD_LO   = 6'h20;
  localparam logic [5:0] OP_LOAD_HI   = 6'h25;
  localparam logic [5:0] OP_STORE_LO  = 6'h28;
  localparam logic [5:0] OP_STORE_HI  = 6'h2B;

  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } snap_state_e;

  // One bit per channel; an instruction may hit several channels at once.
  function automatic logic [NUM_CH-1:0] classify(logic [5:0] op, logic [5:0] funct);
    logic [NUM_CH-1:0] hit;
    hit              = '0;
    hit[CH_R]        = (op == OP_RTYPE);
    hit[CH_J]        = (op == OP_J) || (op == OP_JAL);
    hit[CH_I]        = !hit[CH_R] && !hit[CH_J];
    hit[CH_SYSCALL]  = (op == OP_RTYPE) && (funct == FUNCT_SYSCALL);
    hit[CH_LOAD]     = (op >= OP_LOAD_LO) && (op <= OP_LOAD_HI);
    hit[CH_STORE]    = (op >= OP_STORE_LO) && (op <= OP_STORE_HI);
    hit[CH_BRANCH]   = (op >= OP_BRANCH_LO) && (op <= OP_BRANCH_HI);
    hit[CH_TOTAL]    = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/inst_stat_unit_if.sv
// Retirement, control and readout signals of the statistics unit.
interface inst_stat_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             retire_valid;
  logic [31:0]      inst;
  logic [31:0]      a0;
  logic             clr_req;
  logic             snap_req;
  logic             snap_ack;
  logic [2:0]       rd_idx;
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] live_total;
  logic [7:0]       ovf_flags;
  logic [31:0]      hex_out;
  logic             hex_valid;

  modport master (
    output retire_valid, inst, a0, clr_req, snap_req, rd_idx,
    input  snap_ack, rd_data, live_total, ovf_flags, hex_out, hex_valid
  );

  modport slave (
    input  retire_valid, inst, a0, clr_req, snap_req, rd_idx,
    output snap_ack, rd_data, live_total, ovf_flags, hex_out, hex_valid
  );
endinterface

// File: rtl/stat_counter.sv
// Single event counter with synchronous clear, saturate-or-wrap policy and
// sticky overflow flag.
module stat_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) begin
        if (!SATURATE) begin
          cnt_d = '0;
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/inst_stat_unit.sv
// Retired-instruction statistics: eight class counters, a request/ack
// snapshot bank with registered readout, and a syscall $a0 latch.
module inst_stat_unit
  import stat_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  inst_stat_unit_if.slave bus
);
  typedef logic [CNT_W-1:0] cnt_t;

  logic [NUM_CH-1:0] hit_c;
  logic [NUM_CH-1:0] ovf_c;
  cnt_t              live_c   [NUM_CH];
  cnt_t              shadow_d [NUM_CH];
  cnt_t              shadow_q [NUM_CH];
  cnt_t              rd_data_d, rd_data_q;
  snap_state_e       state_d, state_q;
  logic              snap_ack_d, snap_ack_q;
  logic              capture_c;
  logic [31:0]       hex_d, hex_q;
  logic              hex_valid_d, hex_valid_q;
  logic              unused_inst_c;

  // Only opcode and funct fields take part in classification.
  assign unused_inst_c = ^bus.inst[25:6];
  assign hit_c = bus.retire_valid ? classify(bus.inst[31:26], bus.inst[5:0]) : '0;

  for (genvar ch = 0; ch < int'(NUM_CH); ch++) begin : g_cnt
    stat_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit_c[ch]),
      .clr (bus.clr_req),
      .cnt (live_c[ch]),
      .ovf (ovf_c[ch])
    );
  end

  // Snapshot handshake: capture on entry to ACK, one-cycle ack, wait for release.
  always_comb begin
    state_d    = state_q;
    snap_ack_d = 1'b0;
    capture_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.snap_req) begin
          capture_c  = 1'b1;
          snap_ack_d = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!bus.snap_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shadow copies the counters as they stand before this edge's update.
  always_comb begin
    shadow_d = shadow_q;
    if (capture_c) begin
      shadow_d = live_c;
    end
    rd_data_d   = shadow_q[bus.rd_idx];
    hex_d       = hex_q;
    hex_valid_d = hex_valid_q;
    if (hit_c[CH_SYSCALL]) begin
      hex_d       = bus.a0;
      hex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_ack_q  <= 1'b0;
      shadow_q    <= '{default: '0};
      rd_data_q   <= '0;
      hex_q       <= '0;
      hex_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_ack_q  <= snap_ack_d;
      shadow_q    <= shadow_d;
      rd_data_q   <= rd_data_d;
      hex_q       <= hex_d;
      hex_valid_q <= hex_valid_d;
    end
  end

  assign bus.snap_ack   = snap_ack_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.live_total = live_c[CH_TOTAL];
  assign bus.ovf_flags  = ovf_c;
  assign bus.hex_out    = hex_q;
  assign bus.hex_valid  = hex_valid_q;

endmodule
